ps2_host_writer: RTL and testbench

PS2_HOST_WRITER -- requirements
Module: ps2_host_writer

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_edge_sync.sv | 28 ++
 rtl/ps2_host_writer.sv | 148 ++++++++++++++
 tb/tb_ps2_host_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-writer state encoding, frame bit counts and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAITIDLE
  } state_t;

  localparam int         DATA_BITS = 8;
  localparam logic [3:0] STOP_EDGE = 4'd10;
  localparam logic [3:0] ACK_EDGE  = 4'd11;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge pulse on the synchronized value.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta;
  logic sync_d;

  // Idle PS/2 lines float high, so reset to 1 avoids a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= line;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign fall = sync_d & ~sync;

endmodule

// File: rtl/ps2_host_writer.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, bit shifting on device clock, ACK check, timeout.
module ps2_host_writer
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 360000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       ps2busy,
  output logic       ps2error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    byte_q;
  logic          parity_q;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;
  logic [3:0] edge_num;

  ps2_edge_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .line (ps2clk_ext),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  // The data line's falling edge has no use on the transmit side.
  ps2_edge_sync u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .line (ps2data_ext),
    .sync (data_sync),
    .fall (data_fall_unused)
  );

  // Number of the falling edge currently being detected (1-based).
  assign edge_num = bit_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      ps2busy    <= 1'b0;
      ps2error   <= 1'b0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      byte_q     <= '0;
      parity_q   <= 1'b0;
    end else begin
      if (state != IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (dataload && !ps2busy) begin
            byte_q     <= data;
            parity_q   <= odd_parity(data);
            ps2error   <= 1'b0;
            ps2busy    <= 1'b1;
            ps2clk_oe  <= 1'b1;
            ps2data_oe <= 1'b0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2data_oe <= 1'b1;
            state      <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        REQ: begin
          ps2clk_oe <= 1'b0;
          state     <= SEND;
        end

        SEND: begin
          if (clk_fall) begin
            bit_cnt <= edge_num;
            if (edge_num <= 4'(DATA_BITS)) begin
              ps2data_oe <= ~byte_q[bit_cnt[2:0]];
            end else if (edge_num == STOP_EDGE) begin
              ps2data_oe <= 1'b0;
              state      <= ACK;
            end else begin
              ps2data_oe <= ~parity_q;
            end
          end
        end

        ACK: begin
          if (clk_fall && edge_num == ACK_EDGE) begin
            bit_cnt  <= edge_num;
            ps2error <= data_sync;
            state    <= WAITIDLE;
          end
        end

        WAITIDLE: begin
          if (clk_sync && data_sync) begin
            ps2busy <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Timeout overrides whatever the state logic chose this cycle.
      if (state != IDLE && to_cnt == TO_LAST) begin
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        ps2busy    <= 1'b0;
        ps2error   <= 1'b1;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_writer.sv
// Bench for ps2_host_writer: open-collector bus with a device model and a per-cycle phase model.
module tb_ps2_host_writer;

  localparam int INH = 40;
  localparam int TO  = 2000;
  localparam int H   = 20;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_ENDING = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2clk_ext;
  logic       ps2data_ext;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic [7:0] data;
  logic       dataload;
  logic       ps2busy;
  logic       ps2error;

  logic dev_clk;
  logic dev_data;

  int checks = 0;
  int errors = 0;

  int m_phase = M_IDLE;
  int m_age   = 0;
  bit m_err   = 1'b0;
  bit cmp_en  = 1'b0;

  int run      = 0;
  int last_run = 0;

  logic [10:0] cap;

  always #5 clk = ~clk;

  assign ps2clk_ext  = dev_clk & ~ps2clk_oe;
  assign ps2data_ext = dev_data & ~ps2data_oe;

  ps2_host_writer #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2clk_ext  (ps2clk_ext),
    .ps2data_ext (ps2data_ext),
    .ps2clk_oe   (ps2clk_oe),
    .ps2data_oe  (ps2data_oe),
    .data        (data),
    .dataload    (dataload),
    .ps2busy     (ps2busy),
    .ps2error    (ps2error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase model: what the outputs must be, given cycles since acceptance.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_phase == M_ACTIVE) begin
        m_age++;
        if (m_age == TO) begin
          m_phase = M_IDLE;
          m_err   = 1'b1;
        end
      end
      case (m_phase)
        M_IDLE: begin
          check("cyc idle busy", ps2busy, 0);
          check("cyc idle clk_oe", ps2clk_oe, 0);
          check("cyc idle data_oe", ps2data_oe, 0);
          check("cyc idle error", ps2error, m_err);
        end
        M_ACTIVE: begin
          if (m_age >= 0) begin
            check("cyc busy", ps2busy, 1);
            check("cyc error cleared", ps2error, 0);
            check("cyc clk_oe", ps2clk_oe, (m_age <= INH) ? 1 : 0);
            if (m_age < INH)
              check("cyc inhibit data_oe", ps2data_oe, 0);
            else if (m_age <= INH + 1)
              check("cyc start data_oe", ps2data_oe, 1);
          end
        end
        default: check("cyc ending clk_oe", ps2clk_oe, 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (ps2clk_oe === 1'b1) begin
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic load(input logic [7:0] b);
    @(posedge clk); #1;
    data     = b;
    dataload = 1'b1;
    if (m_phase == M_IDLE) begin
      m_phase = M_ACTIVE;
      m_age   = -2;
    end
    @(posedge clk); #1;
    dataload = 1'b0;
  endtask

  // Device side: waits for request-to-send, clocks 11 edges, checks each presented bit.
  task automatic device_xfer(input logic [7:0] b, input bit ack, input int abort_fall,
                             output logic [10:0] c);
    logic [10:0] frame;
    bit found;
    frame = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    c = '0;
    found = 1'b0;
    for (int i = 0; i < 4 * INH + 200 && !found; i++) begin
      @(posedge clk); #1;
      if (ps2busy === 1'b1 && ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) found = 1'b1;
    end
    check("request to send seen", found, 1);
    if (!found) return;
    repeat (H) @(posedge clk);
    #1;
    check("start bit", ps2data_ext, 0);
    c[0] = ps2data_ext;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) m_phase = M_ENDING;
      dev_clk = 1'b0;
      if (k <= 10) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("bit %0d within 3 cycles", k), ps2data_ext, frame[k]);
        if (k == abort_fall) return;
        repeat (H - 4) @(posedge clk);
      end else begin
        repeat (H - 1) @(posedge clk);
      end
      #1;
      dev_clk = 1'b1;
      if (k <= 10) c[k] = ps2data_ext;
      if (k == 10 && ack) dev_data = 1'b0;
      repeat (H) @(posedge clk);
      #1;
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_xfer(input bit ack);
    repeat (6) @(posedge clk);
    #1;
    m_phase = M_IDLE;
    m_err   = ~ack;
  endtask

  initial begin
    rst      = 1'b1;
    dataload = 1'b0;
    data     = '0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    cap      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset clk_oe", ps2clk_oe, 0);
    check("reset data_oe", ps2data_oe, 0);
    check("reset busy", ps2busy, 0);
    check("reset error", ps2error, 0);
    cmp_en = 1'b1;

    load(8'hED);
    device_xfer(8'hED, 1'b1, 0, cap);
    finish_xfer(1'b1);
    check("ED frame", cap, 11'b11111011010);
    check("ED error", ps2error, 0);
    check("ED busy", ps2busy, 0);
    check("ED clock low run", last_run, INH + 1);

    load(8'hFF);
    device_xfer(8'hFF, 1'b0, 0, cap);
    finish_xfer(1'b0);
    check("FF frame", cap, 11'b11111111110);
    check("FF nack error", ps2error, 1);

    load(8'h00);
    @(negedge clk);
    check("00 load clears error", ps2error, 0);
    repeat (TO + 5) @(posedge clk);
    #1;
    check("timeout error", ps2error, 1);
    check("timeout busy", ps2busy, 0);
    check("timeout clk_oe", ps2clk_oe, 0);
    check("timeout data_oe", ps2data_oe, 0);

    load(8'hAA);
    fork
      device_xfer(8'hAA, 1'b1, 0, cap);
      begin
        repeat (150) @(posedge clk);
        load(8'h55);
      end
    join
    finish_xfer(1'b1);
    check("AA frame ignores 55", cap, 11'b11101010100);
    check("AA error", ps2error, 0);

    load(8'h12);
    device_xfer(8'h12, 1'b1, 5, cap);
    @(posedge clk); #1;
    m_phase = M_ENDING;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    m_phase  = M_IDLE;
    m_err    = 1'b0;
    @(negedge clk);
    check("midreset clk_oe", ps2clk_oe, 0);
    check("midreset data_oe", ps2data_oe, 0);
    check("midreset busy", ps2busy, 0);
    check("midreset error", ps2error, 0);
    repeat (4) @(posedge clk);

    load(8'hF4);
    device_xfer(8'hF4, 1'b1, 0, cap);
    finish_xfer(1'b1);
    check("F4 frame", cap, 11'b10111101000);
    check("F4 error", ps2error, 0);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
